dram: RTL and testbench
=======================

// Module: dram
// PURPOSE
//  - Dual-port word-addressed data memory for the MIPS32 core. Each port has an independent
//    address, chip select, read/write strobe and bidirectional 32-bit data bus.
//  - Sits between the pipeline's memory stage and the data bus.
//  - Writes are synchronous; reads are registered with 1-cycle latency and driven back
//    onto the shared inout bus.
// PARAMETERS
//  ADDR_WIDTH  12  word-address bits actually decoded; depth = 2**ADDR_WIDTH = 4096 words
//  DATA_WIDTH  32  word width
// PORTS
//  CLK    in     1   single clock; all state changes on rising edge, except reset
//  RST_N  in     1   asynchronous, active-low reset
//  Addr1  in     32  port-1 word address; only Addr1[ADDR_WIDTH-1:0] is used
//  Data1  inout  32  port-1 data: write data in, read data out
//  CS1    in     1   port-1 chip select, active high
//  R_W1   in     1   port-1 direction: 1 = read, 0 = write
//  Addr2  in     32  port-2 word address; only Addr2[ADDR_WIDTH-1:0] is used
//  Data2  inout  32  port-2 data
//  CS2    in     1   port-2 chip select
//  R_W2   in     1   port-2 direction
// BEHAVIOUR
//  - Reset (RST_N=0, async):
//    - all memory words <= 0; both read registers <= 0.
//    - Data1/Data2 are released to 'z while RST_N=0.
//  - Write:
//    - on posedge CLK with CSx=1 and R_Wx=0, mem[Addrx[11:0]] <= Datax.
//    - Datax is driven externally and the block never drives it while R_Wx=0.
//  - Read:
//    - on posedge CLK with CSx=1 and R_Wx=1, rdregx <= mem[Addrx[11:0]].
//    - Latency is one edge: data addressed before edge N is visible after edge N.
//  - Output enable:
//    - Datax = rdregx when CSx=1 and R_Wx=1, else 'z (combinational).
//    - The bus is never driven during a write or while deselected.
//  - Idle: CSx=0 means no memory update and no register update; rdregx holds its value.
//  - Address wrap: upper address bits [31:ADDR_WIDTH] are ignored, so address 0x1000
//    aliases word 0.
//  - Same-address write/write on the same edge: port 2 wins.
//  - Read/write to the same address on the same edge (cross-port):
//    - the read returns the OLD contents (read-before-write);
//    - the new data is visible on the next read.
//  - Different addresses: the two ports are fully independent and concurrent.
//  - Reset mid-operation: a pending write on the edge coincident with RST_N=0 is discarded.
//    Memory is zero after reset is released.
//  - No X propagation from unwritten words: all words are defined 0 after reset.
// STRUCTURE
//  - Shared package dram_pkg:
//    - localparams DRAM_ADDR_W=12, DRAM_DATA_W=32;
//    - enum/constants RW_READ=1'b1, RW_WRITE=1'b0.
//  - Top holds the memory array and the write arbitration (port-2 priority).
//  - One sub-module, dram_port (instantiated x2), holds:
//    - the read register;
//    - the output-enable logic and the tristate driver for one Data bus.
//  - dram_port takes the read word from the array plus CS/R_W, and returns the write-enable
//    and the bus value.
// TESTING
//  1. Dual write:
//     - edge 1: A1=0/D1=DEADBEEF, A2=1/D2=BAADF00D;
//     - edge 2: A1=2/CCCCCCCC, A2=3/22222222 (writes);
//     - read A1=0, A2=1 -> Data1=DEADBEEF, Data2=BAADF00D one edge later.
//  2. Sequential fill:
//     - write mem[i]=i for i=0..19 via port 1;
//     - read back i=0..19 -> each Data1 equals i, one cycle after the address is presented.
//  3. Collision:
//     - both ports write addr 5 (port 1 = 11111111, port 2 = 22222222) -> readback 22222222;
//     - then read+write on addr 5 in the same edge -> read returns old value, next read
//       returns new value.
//  4. Tristate:
//     - CS=0, or R_W=0 -> bus 'z (bench drives/pulls);
//     - CS=1 with R_W=1 -> bus driven.
//     - Check no contention while the bench drives writes.
//  5. Async reset:
//     - write 7F7F6262@2, AABB8822@4, 27274433@6;
//     - pulse RST_N low between clock edges -> read @2/@4/@6 returns 00000000;
//     - Data is 'z during the reset pulse.
//  6. Alias: write 0x1002=12345678 -> read addr 2 returns 12345678.

Source files
------------

// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dram_pkg
// Brief   : Shared sizes, direction encoding and address helper for the
//           dual-port MIPS32 data memory.
// Revision: 1.0 - initial release
// ============================================================================
package dram_pkg;

  localparam int DRAM_ADDR_W = 12;
  localparam int DRAM_DATA_W = 32;
  localparam int DRAM_DEPTH  = 1 << DRAM_ADDR_W;

  // Direction strobe encoding shared by both ports.
  typedef enum logic {
    RW_WRITE = 1'b0,
    RW_READ  = 1'b1
  } rw_e;

  typedef logic [DRAM_DATA_W-1:0] word_t;
  typedef logic [DRAM_ADDR_W-1:0] word_addr_t;

  // Only the low address bits are decoded; upper bits alias onto the array.
  function automatic word_addr_t word_index(input logic [31:0] addr);
    return addr[DRAM_ADDR_W-1:0];
  endfunction

endpackage : dram_pkg
`default_nettype wire

// File: rtl/dram_port.sv
`default_nettype none
// ============================================================================
// Module  : dram_port
// Brief   : One access port of the data memory: read register, strobe
//           decode and the tristate driver for that port's data bus.
// Revision: 1.0 - initial release
// ============================================================================
module dram_port
  import dram_pkg::*;
#(
  parameter int DATA_WIDTH = DRAM_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  r_w,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  inout  wire  [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] rd_reg;
  logic                  rd_en;
  logic                  oe;

  assign rd_en   = cs && (r_w == RW_READ);
  assign wr_en   = cs && (r_w == RW_WRITE);
  // Write data is whatever the external master places on the bus.
  assign wr_data = data;

  // Capture the addressed word on a read; hold it while idle or writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_reg <= '0;
    end else if (rd_en) begin
      rd_reg <= rd_word;
    end
  end

  // The bus is only driven for an active read and always released in reset.
  assign oe   = rd_en && rst_n;
  assign data = oe ? rd_reg : 'z;

endmodule : dram_port
`default_nettype wire

// File: rtl/dram.sv
`default_nettype none
// ============================================================================
// Module  : dram
// Brief   : Dual-port word-addressed data memory. Synchronous writes with
//           port-2 priority on address collision, registered reads with
//           read-before-write semantics, tristate data buses.
// Revision: 1.0 - initial release
// ============================================================================
module dram
  import dram_pkg::*;
#(
  parameter int ADDR_WIDTH = DRAM_ADDR_W,
  parameter int DATA_WIDTH = DRAM_DATA_W
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [31:0]           Addr1,
  inout  wire  [DATA_WIDTH-1:0] Data1,
  input  logic                  CS1,
  input  logic                  R_W1,
  input  logic [31:0]           Addr2,
  inout  wire  [DATA_WIDTH-1:0] Data2,
  input  logic                  CS2,
  input  logic                  R_W2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx1;
  logic [ADDR_WIDTH-1:0] idx2;
  logic [DATA_WIDTH-1:0] rd_word1;
  logic [DATA_WIDTH-1:0] rd_word2;
  logic [DATA_WIDTH-1:0] wr_data1;
  logic [DATA_WIDTH-1:0] wr_data2;
  logic                  wr_en1;
  logic                  wr_en2;
  logic                  unused_addr_bits;

  assign idx1 = Addr1[ADDR_WIDTH-1:0];
  assign idx2 = Addr2[ADDR_WIDTH-1:0];
  // Upper address bits are deliberately ignored so addresses wrap.
  assign unused_addr_bits = ^{Addr1[31:ADDR_WIDTH], Addr2[31:ADDR_WIDTH]};

  // Array lookups feed the port read registers; they see pre-edge contents,
  // which gives read-before-write on a same-address cross-port access.
  assign rd_word1 = mem[idx1];
  assign rd_word2 = mem[idx2];

  // Memory array: cleared on reset, port 2 assigned last so it wins collisions.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en1) begin
        mem[idx1] <= wr_data1;
      end
      if (wr_en2) begin
        mem[idx2] <= wr_data2;
      end
    end
  end

  dram_port #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_port1 (
    .clk     (CLK),
    .rst_n   (RST_N),
    .cs      (CS1),
    .r_w     (R_W1),
    .rd_word (rd_word1),
    .wr_en   (wr_en1),
    .wr_data (wr_data1),
    .data    (Data1)
  );

  dram_port #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_port2 (
    .clk     (CLK),
    .rst_n   (RST_N),
    .cs      (CS2),
    .r_w     (R_W2),
    .rd_word (rd_word2),
    .wr_en   (wr_en2),
    .wr_data (wr_data2),
    .data    (Data2)
  );

endmodule : dram
`default_nettype wire

// File: tb/tb_dram.sv
`default_nettype none
// ============================================================================
// Module  : tb_dram
// Brief   : Self-checking bench for dram: directed scenarios plus random
//           traffic compared against an array-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dram;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  logic        CLK;
  logic        RST_N;
  logic [31:0] Addr1, Addr2;
  logic        CS1, CS2, R_W1, R_W2;
  wire  [31:0] Data1, Data2;

  logic        drv_en1, drv_en2;
  logic [31:0] drv_val1, drv_val2;

  // Bench-side bus drivers; released whenever the DUT is expected to drive.
  assign Data1 = drv_en1 ? drv_val1 : 'z;
  assign Data2 = drv_en2 ? drv_val2 : 'z;

  // Reference model: plain word array plus the last word read on each port.
  logic [31:0] m_mem [4096];
  logic [31:0] m_rd1, m_rd2;

  int vectors;
  int miscompares;

  dram dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .Addr1 (Addr1),
    .Data1 (Data1),
    .CS1   (CS1),
    .R_W1  (R_W1),
    .Addr2 (Addr2),
    .Data2 (Data2),
    .CS2   (CS2),
    .R_W2  (R_W2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) m_mem[i] = 32'h0;
    m_rd1 = 32'h0;
    m_rd2 = 32'h0;
  endtask

  // One clock of traffic: drive both ports, update the model, then check both buses.
  task automatic cycle(input string tag,
                       input logic c1, input logic r1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic c2, input logic r2, input logic [31:0] a2, input logic [31:0] d2);
    logic [31:0] exp1, exp2;
    CS1 = c1; R_W1 = r1; Addr1 = a1;
    CS2 = c2; R_W2 = r2; Addr2 = a2;
    drv_en1 = !(c1 && r1); drv_val1 = d1;
    drv_en2 = !(c2 && r2); drv_val2 = d2;
    // Reads see the old contents; writes land afterwards, port 2 last.
    if (c1 && r1) m_rd1 = m_mem[a1[11:0]];
    if (c2 && r2) m_rd2 = m_mem[a2[11:0]];
    if (c1 && !r1) m_mem[a1[11:0]] = d1;
    if (c2 && !r2) m_mem[a2[11:0]] = d2;
    exp1 = (c1 && r1) ? m_rd1 : d1;
    exp2 = (c2 && r2) ? m_rd2 : d2;
    @(posedge CLK);
    #1;
    check({tag, "/p1"}, Data1, exp1);
    check({tag, "/p2"}, Data2, exp2);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST_N = 1'b0;
    CS1 = 1'b0; CS2 = 1'b0; R_W1 = RD; R_W2 = RD;
    Addr1 = '0; Addr2 = '0;
    drv_en1 = 1'b1; drv_en2 = 1'b1;
    drv_val1 = '0; drv_val2 = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;

    // Reset state: read registers and array are zero.
    cycle("rst_state", 1, RD, 32'd0, 32'h0, 1, RD, 32'd4095, 32'h0);

    // Dual write then dual read.
    cycle("dual_wr_a", 1, WR, 32'd0, 32'hDEADBEEF, 1, WR, 32'd1, 32'hBAADF00D);
    cycle("dual_wr_b", 1, WR, 32'd2, 32'hCCCCCCCC, 1, WR, 32'd3, 32'h22222222);
    cycle("dual_rd",   1, RD, 32'd0, 32'h0,        1, RD, 32'd1, 32'h0);
    cycle("dual_rd2",  1, RD, 32'd2, 32'h0,        1, RD, 32'd3, 32'h0);

    // Sequential fill and readback through port 1, port 2 idle.
    for (int i = 0; i < 20; i++)
      cycle("fill_wr", 1, WR, i, i, 0, RD, 32'd0, $urandom());
    for (int i = 0; i < 20; i++)
      cycle("fill_rd", 1, RD, i, 32'h0, 0, WR, 32'd0, $urandom());

    // Idle holds the read register.
    cycle("idle_hold", 0, RD, 32'd7, 32'h13572468, 0, RD, 32'd9, 32'h24681357);
    cycle("hold_rd",   1, RD, 32'd19, 32'h0,       0, RD, 32'd9, 32'h0);

    // Write/write collision: port 2 wins.
    cycle("coll_ww",  1, WR, 32'd5, 32'h11111111, 1, WR, 32'd5, 32'h22222222);
    cycle("coll_rd",  1, RD, 32'd5, 32'h0,        0, RD, 32'd0, 32'hA5A5A5A5);
    // Cross-port read/write same edge: read-before-write.
    cycle("coll_rw",  1, RD, 32'd5, 32'h0,        1, WR, 32'd5, 32'h33333333);
    cycle("coll_new", 1, RD, 32'd5, 32'h0,        1, RD, 32'd5, 32'h0);
    cycle("coll_wr2", 1, WR, 32'd6, 32'h44444444, 1, RD, 32'd6, 32'h0);
    cycle("coll_rd2", 0, RD, 32'd0, 32'h0,        1, RD, 32'd6, 32'h0);

    // Tristate: deselected and write phases must leave the bench's value intact.
    cycle("tri_desel", 0, RD, 32'd2, 32'h0F0F0F0F, 0, WR, 32'd3, 32'hF0F0F0F0);
    cycle("tri_write", 1, WR, 32'd8, 32'h00000000, 1, WR, 32'd9, 32'h00000000);
    cycle("tri_drive", 1, RD, 32'd2, 32'h0,        1, RD, 32'd3, 32'h0);

    // Async reset pulse with a pending write on the edge inside the pulse.
    cycle("rst_wr2", 1, WR, 32'd2, 32'h7F7F6262, 1, WR, 32'd4, 32'hAABB8822);
    cycle("rst_wr6", 1, WR, 32'd6, 32'h27274433, 0, RD, 32'd0, 32'h0);
    cycle("rst_prime", 1, RD, 32'd2, 32'h0,      1, RD, 32'd4, 32'h0);
    #2;
    CS1 = 1'b1; R_W1 = RD; Addr1 = 32'd6;
    CS2 = 1'b1; R_W2 = WR; Addr2 = 32'd10;
    drv_en1 = 1'b1; drv_val1 = 32'h5A5A5A5A;
    drv_en2 = 1'b1; drv_val2 = 32'h0BADCAFE;
    RST_N = 1'b0;
    #1;
    check("rst_bus1", Data1, 32'h5A5A5A5A);
    check("rst_bus2", Data2, 32'h0BADCAFE);
    @(posedge CLK);
    #2;
    check("rst_bus1b", Data1, 32'h5A5A5A5A);
    RST_N = 1'b1;
    model_reset();
    cycle("rst_rd24", 1, RD, 32'd2, 32'h0, 1, RD, 32'd4, 32'h0);
    cycle("rst_rd6",  1, RD, 32'd6, 32'h0, 1, RD, 32'd10, 32'h0);

    // Address alias: upper bits ignored.
    cycle("alias_wr", 1, WR, 32'h00001002, 32'h12345678, 0, RD, 32'd0, 32'h0);
    cycle("alias_rd", 1, RD, 32'd2, 32'h0, 1, RD, 32'hFFFFF002, 32'h0);

    // Random traffic over a small aliased window to force collisions.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra1, ra2;
      ra1 = ($urandom_range(0, 3) << 12) | $urandom_range(0, 15);
      ra2 = ($urandom_range(0, 3) << 12) | $urandom_range(0, 15);
      cycle("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra1, $urandom(),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra2, $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dram
`default_nettype wire
